// File: rtl/disp_capture_pkg.sv
// Shared types and constants for the 7-segment display capture block.
// The glyph table is indexed by nibble value; patterns are active-low abcdefg.
package disp_capture_pkg;

  localparam int unsigned SETTLE_DEFAULT  = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_COMMIT
  } state_e;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/disp_capture_seg7_decode.sv
// Combinational reverse decode of an active-low abcdefg pattern to a hex nibble.
module seg7_decode
  import disp_capture_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       ok_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    nibble_o = 4'd0;
    ok_o     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == GLYPH[i]) begin
        nibble_o = 4'(i);
        ok_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_capture.sv
// Captures frames from a multiplexed 4-digit 7-segment display bus.
// Optional build macro DISP_CAPTURE_CONFIRM_EN: commit only on two identical good frames.
module disp_capture
  import disp_capture_pkg::*;
#(
  parameter int unsigned SETTLE  = SETTLE_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        timeout
);

  localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
  localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0]      an_q;
  logic [7:0]      settle_q, settle_d, run;
  logic [23:0]     idle_q, idle_d;
  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0]      mask_q, mask_d, bad_q, bad_d;
  logic [15:0]     value_q, value_d;
  logic            valid_q, valid_d, done_q, done_d, err_q, err_d, to_q, to_d;
  logic            an_legal, sample, ok;
  logic [3:0]      nibble;
  logic [1:0]      slot;
`ifdef DISP_CAPTURE_CONFIRM_EN
  logic [15:0]     cand_q, cand_d;
`endif

  seg7_decode u_decode (
    .seg_i    (seg),
    .nibble_o (nibble),
    .ok_o     (ok)
  );

  assign an_legal = $onehot(~an);

  always_comb begin
    slot = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) slot = 2'(i);
    end
  end

  // Stable-run length of the current anode pattern, saturating at SETTLE; sample on arrival.
  always_comb begin
    if (an != an_q)             run = 8'd1;
    else if (settle_q == SETTLE_C) run = settle_q;
    else                        run = settle_q + 8'd1;
    settle_d = an_legal ? run : 8'd0;
    sample   = an_legal && (run == SETTLE_C) && ((an != an_q) || (settle_q != SETTLE_C));
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    mask_d  = mask_q;
    bad_d   = bad_q;
    value_d = value_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    to_d    = to_q;
    idle_d  = idle_q;
`ifdef DISP_CAPTURE_CONFIRM_EN
    cand_d  = cand_q;
`endif

    unique case (state_q)
      ST_IDLE:    if (sample) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (mask_q == 4'b1111) begin
          state_d = ST_COMMIT;
          if (bad_q == 4'b0000) begin
`ifdef DISP_CAPTURE_CONFIRM_EN
            if (digit_q == cand_q) begin
              value_d = digit_q;
              valid_d = 1'b1;
              done_d  = 1'b1;
            end
            cand_d = digit_q;
`else
            value_d = digit_q;
            valid_d = 1'b1;
            done_d  = 1'b1;
`endif
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_COLLECT;
        mask_d  = 4'b0000;
        bad_d   = 4'b0000;
      end
      default:    state_d = ST_IDLE;
    endcase

    // A sample always beats a timeout landing on the same cycle.
    if (sample) begin
      digit_d[slot] = nibble;
      mask_d[slot]  = 1'b1;
      bad_d[slot]   = !ok;
      err_d         = !ok;
      idle_d        = 24'd0;
      to_d          = 1'b0;
    end else if (idle_q != TIMEOUT_C) begin
      idle_d = idle_q + 24'd1;
      if (idle_q == TO_LAST) begin
        to_d    = 1'b1;
        valid_d = 1'b0;
        mask_d  = 4'b0000;
        bad_d   = 4'b0000;
        state_d = ST_IDLE;
        value_d = value_q;
        done_d  = 1'b0;
`ifdef DISP_CAPTURE_CONFIRM_EN
        cand_d  = 16'h0000;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q     <= 4'b1111;
      settle_q <= 8'd0;
      idle_q   <= 24'd0;
      mask_q   <= 4'b0000;
      bad_q    <= 4'b0000;
      value_q  <= 16'h0000;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
`ifdef DISP_CAPTURE_CONFIRM_EN
      cand_q   <= 16'h0000;
`endif
    end else begin
      an_q     <= an;
      settle_q <= settle_d;
      idle_q   <= idle_d;
      mask_q   <= mask_d;
      bad_q    <= bad_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      to_q     <= to_d;
`ifdef DISP_CAPTURE_CONFIRM_EN
      cand_q   <= cand_d;
`endif
    end
  end

  // NOTE: digit slots carry no reset; mask_q gates every use, so stale contents are never seen.
  always_ff @(posedge clk) begin
    digit_q <= digit_d;
  end

  assign value      = value_q;
  assign valid      = valid_q;
  assign frame_done = done_q;
  assign seg_err    = err_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_disp_capture.sv
// Self-checking bench for disp_capture: directed scenarios plus randomized scans
// compared cycle by cycle against a frame-level reference model.
module tb_disp_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        valid, frame_done, seg_err, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_fd   = 0;
  int dut_err  = 0;

  always #5 clk = ~clk;

  disp_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .an         (an),
    .seg        (seg),
    .value      (value),
    .valid      (valid),
    .frame_done (frame_done),
    .seg_err    (seg_err),
    .timeout    (timeout)
  );

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state: frame-level view of slots, commits and timeout.
  logic [3:0]  m_slot [4];
  bit          m_set [4];
  bit          m_bad [4];
  int          m_since;
  bit          m_to, m_valid, m_pend, m_frame_bad;
  logic [15:0] m_value, m_cand, m_frame;
  int          seg_idx;
  logic [3:0]  last_an;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_set[i] = 0;
      m_bad[i] = 0;
      m_slot[i] = 4'd0;
    end
    m_since = 0; m_to = 0; m_valid = 0; m_pend = 0; m_frame_bad = 0;
    m_value = 16'h0; m_cand = 16'h0; m_frame = 16'h0;
  endfunction

  function automatic void decode(input logic [6:0] s, output logic [3:0] n, output bit ok);
    n = 4'd0; ok = 0;
    for (int i = 0; i < 16; i++) if (glyph[i] == s) begin n = 4'(i); ok = 1; end
  endfunction

  task automatic tick(input logic [3:0] a, input logic [6:0] s);
    bit smp, exp_fd, exp_err, ok, full;
    logic [3:0] nib;
    int slot;
    an = a; seg = s;
    smp = ($countones(~a) == 1) && (seg_idx == SETTLE - 1);
    @(posedge clk); #1;
    seg_idx++;
    exp_fd = 0; exp_err = 0;
    if (m_pend) begin
      m_pend = 0;
      if (!m_frame_bad) begin
`ifdef DISP_CAPTURE_CONFIRM_EN
        if (m_frame == m_cand) begin m_value = m_frame; m_valid = 1; exp_fd = 1; end
        m_cand = m_frame;
`else
        m_value = m_frame; m_valid = 1; exp_fd = 1;
`endif
      end
    end
    if (smp) begin
      decode(s, nib, ok);
      slot = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) slot = i;
      m_slot[slot] = nib; m_set[slot] = 1; m_bad[slot] = !ok;
      exp_err = !ok; m_since = 0; m_to = 0;
      full = m_set[0] && m_set[1] && m_set[2] && m_set[3];
      if (full) begin
        m_frame = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_frame_bad = m_bad[0] || m_bad[1] || m_bad[2] || m_bad[3];
        m_pend = 1;
        for (int i = 0; i < 4; i++) begin m_set[i] = 0; m_bad[i] = 0; end
      end
    end else if (m_since < TIMEOUT) begin
      m_since++;
      if (m_since == TIMEOUT) begin
        m_to = 1; m_valid = 0; m_cand = 16'h0;
        for (int i = 0; i < 4; i++) begin m_set[i] = 0; m_bad[i] = 0; end
      end
    end
    if (frame_done === 1'b1) dut_fd++;
    if (seg_err === 1'b1) dut_err++;
    check("value", 32'(value), 32'(m_value));
    check("valid", 32'(valid), 32'(m_valid));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("seg_err", 32'(seg_err), 32'(exp_err));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  // Holds one anode pattern for dwell cycles; a repeated legal pattern gets a blank gap first.
  task automatic show(input logic [3:0] a, input logic [6:0] s, input int dwell);
    if (($countones(~a) == 1) && (a == last_an)) begin
      seg_idx = 0;
      tick(4'hF, 7'h7F);
    end
    seg_idx = 0;
    last_an = a;
    repeat (dwell) tick(a, s);
  endtask

  task automatic scan(input logic [15:0] v);
    show(4'b0111, glyph[v[15:12]], 8);
    show(4'b1011, glyph[v[11:8]], 8);
    show(4'b1101, glyph[v[7:4]], 8);
    show(4'b1110, glyph[v[3:0]], 8);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (cycles) @(posedge clk);
    #1;
    model_clear();
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    last_an = 4'hF;
    seg_idx = 0;
  endtask

  logic [3:0] legal_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] multi_an [5] = '{4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b1100};

  initial begin
    int fd0, err0, kind, rdw;
    logic [3:0] ra;
    logic [6:0] rs;

    model_clear();
    do_reset(3);

    // Natural scan order, two frames.
    fd0 = dut_fd;
    scan(16'h1234);
    scan(16'h1234);
`ifdef DISP_CAPTURE_CONFIRM_EN
    check("scan1234_pulses", 32'(dut_fd - fd0), 32'd1);
`else
    check("scan1234_pulses", 32'(dut_fd - fd0), 32'd2);
`endif
    check("scan1234_value", 32'(value), 32'h1234);
    check("scan1234_valid", 32'(valid), 32'h1);

    // Out-of-order scan.
    repeat (2) begin
      show(4'b1110, glyph[15], 8);
      show(4'b1011, glyph[13], 8);
      show(4'b1101, glyph[14], 8);
      show(4'b0111, glyph[12], 8);
    end
    check("scan_order_value", 32'(value), 32'hCDEF);

    // Illegal glyph inside a frame.
    scan(16'h1234);
    scan(16'h1234);
    fd0 = dut_fd; err0 = dut_err;
    show(4'b0111, glyph[1], 8);
    show(4'b1011, glyph[2], 8);
    show(4'b1101, 7'b1111111, 8);
    show(4'b1110, glyph[4], 8);
    repeat (4) tick(4'hF, 7'h7F);
    check("bad_glyph_err", 32'(dut_err - err0), 32'd1);
    check("bad_glyph_no_commit", 32'(dut_fd - fd0), 32'd0);
    check("bad_glyph_value", 32'(value), 32'h1234);

    // Sample arriving on the exact cycle the timeout would fire.
    do_reset(2);
    show(4'b0111, glyph[1], 8);
    show(4'hF, 7'h7F, 42);
    show(4'b1011, glyph[2], 8);
    check("sample_beats_timeout", 32'(timeout), 32'h0);

    // Dwell too short to settle, then reset mid-frame.
    fd0 = dut_fd; err0 = dut_err;
    show(4'b0111, glyph[1], SETTLE - 1);
    show(4'b1011, glyph[2], SETTLE - 1);
    show(4'b1101, glyph[3], SETTLE - 1);
    show(4'b1110, glyph[4], SETTLE - 1);
    check("short_dwell_no_commit", 32'(dut_fd - fd0), 32'd0);
    show(4'b0111, glyph[1], 8);
    show(4'b1011, glyph[2], 8);
    do_reset(1);
    fd0 = dut_fd;
    show(4'b1101, glyph[3], 8);
    show(4'b1110, glyph[4], 8);
    repeat (4) tick(4'hF, 7'h7F);
    check("reset_discards_partial", 32'(dut_fd - fd0), 32'd0);

    // Timeout from reset with a blank display.
    do_reset(2);
    repeat (TIMEOUT - 1) tick(4'hF, 7'h7F);
    check("timeout_not_yet", 32'(timeout), 32'h0);
    tick(4'hF, 7'h7F);
    check("timeout_at_limit", 32'(timeout), 32'h1);
    check("timeout_valid_low", 32'(valid), 32'h0);
    show(4'b1110, glyph[5], 8);
    check("timeout_cleared", 32'(timeout), 32'h0);

    // Randomized scans against the model.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        ra  = legal_an[$urandom_range(0, 3)];
        rs  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
        rdw = $urandom_range(1, 12);
      end else if (kind < 9) begin
        ra  = 4'hF;
        rs  = 7'($urandom);
        rdw = $urandom_range(1, 60);
      end else begin
        ra  = multi_an[$urandom_range(0, 4)];
        rs  = glyph[$urandom_range(0, 15)];
        rdw = $urandom_range(1, 8);
      end
      show(ra, rs, rdw);
    end

`ifdef DISP_CAPTURE_CONFIRM_EN
    do_reset(2);
    fd0 = dut_fd;
    scan(16'hAAAA);
    repeat (4) tick(4'hF, 7'h7F);
    check("confirm_first_no_commit", 32'(dut_fd - fd0), 32'd0);
    check("confirm_first_value", 32'(value), 32'h0);
    scan(16'hAAAA);
    repeat (4) tick(4'hF, 7'h7F);
    check("confirm_second_commit", 32'(dut_fd - fd0), 32'd1);
    check("confirm_second_value", 32'(value), 32'hAAAA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
